// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//   Shares the single frame-buffer SRAM write port between the draw engines
//   (room, player, enemy, HUD) using round-robin arbitration with burst
//   locking. Also owns the double-buffer select, which is swapped during
//   vertical sync once the draw sequencer reports the frame as complete.
//
// Ports
//   CLK, RESET_N      system clock, asynchronous active-low reset
//   VGA_VS            vertical sync (active low, synchronous to CLK)
//   FrameDone         one-cycle pulse: all layers of this frame have been issued
//   Req/Addr/Data/Last per-requester pixel stream (slice i = requester i)
//   Grant, Ack        current owner (one-hot or zero), pixel accepted this cycle
//   MEM_WE/ADDR/WDATA registered SRAM write, MEM_ADDR MSB = BufSel
//   MEM_READY         SRAM accepts the write this cycle
//   BufSel            buffer being drawn; scan-out reads ~BufSel
//   SwapPending       frame complete, waiting for vsync
//   Busy              grant active or write register occupied
module fb_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      VGA_VS,
  input  logic                      FrameDone,
  input  logic [N_REQ-1:0]          Req,
  input  logic [N_REQ*ADDR_W-1:0]   Addr,
  input  logic [N_REQ*DATA_W-1:0]   Data,
  input  logic [N_REQ-1:0]          Last,
  output logic [N_REQ-1:0]          Grant,
  output logic [N_REQ-1:0]          Ack,
  output logic                      MEM_WE,
  output logic [ADDR_W:0]           MEM_ADDR,
  output logic [DATA_W-1:0]         MEM_WDATA,
  input  logic                      MEM_READY,
  output logic                      BufSel,
  output logic                      SwapPending,
  output logic                      Busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, SWAP_WAIT} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               buf_sel_q, buf_sel_d;
  logic               swap_pending_q, swap_pending_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

  logic               load;
  logic               xfer;
  logic [N_REQ-1:0]   ack;
  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   idx;
  logic [PTR_W-1:0]   owner_next;

  // The output register can take a new pixel when empty or being drained
  // this cycle; Ack is only ever given to the (single) granted requester.
  always_comb begin
    load = !mem_we_q | MEM_READY;
    ack  = grant_q & Req & {N_REQ{load}};
    xfer = |ack;
  end

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % N_REQ);
      if (!found && Req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    owner_next = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + PTR_W'(1);
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    owner_d        = owner_q;
    ptr_d          = ptr_q;
    buf_sel_d      = buf_sel_q;
    swap_pending_d = swap_pending_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;

    // A second FrameDone while a swap is already pending is ignored.
    if (FrameDone && !swap_pending_q) begin
      swap_pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // A frame completion seen this cycle beats any waiting requester.
        if (swap_pending_q || FrameDone) begin
          state_d = DRAIN;
        end else if (found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          owner_d       = pick;
          state_d       = GRANT;
        end
      end
      GRANT: begin
        // Release on the last accepted pixel or when the owner walks away.
        if (!Req[owner_q] || (xfer && Last[owner_q])) begin
          grant_d = '0;
          ptr_d   = owner_next;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        // The buffer may only flip once no write is held for the old one.
        if (!mem_we_q) begin
          state_d = SWAP_WAIT;
        end
      end
      SWAP_WAIT: begin
        if (!VGA_VS) begin
          buf_sel_d      = ~buf_sel_q;
          swap_pending_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      mem_we_d = xfer;
      if (xfer) begin
        mem_addr_d  = {buf_sel_q, Addr[int'(owner_q)*ADDR_W +: ADDR_W]};
        mem_wdata_d = Data[int'(owner_q)*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      owner_q        <= '0;
      ptr_q          <= '0;
      buf_sel_q      <= 1'b0;
      swap_pending_q <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      owner_q        <= owner_d;
      ptr_q          <= ptr_d;
      buf_sel_q      <= buf_sel_d;
      swap_pending_q <= swap_pending_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
    end
  end

  assign Grant       = grant_q;
  assign Ack         = ack;
  assign MEM_WE      = mem_we_q;
  assign MEM_ADDR    = mem_addr_q;
  assign MEM_WDATA   = mem_wdata_q;
  assign BufSel      = buf_sel_q;
  assign SwapPending = swap_pending_q;
  assign Busy        = (|grant_q) | mem_we_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter
//   Directed self-checking bench for fb_write_arbiter. Inputs are driven 1ns
//   after the rising edge, outputs are sampled on the falling edge.
module tb_fb_write_arbiter;

  logic        CLK;
  logic        RESET_N;
  logic        VGA_VS;
  logic        FrameDone;
  logic [3:0]  Req;
  logic [75:0] Addr;
  logic [31:0] Data;
  logic [3:0]  Last;
  logic [3:0]  Grant;
  logic [3:0]  Ack;
  logic        MEM_WE;
  logic [19:0] MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic        MEM_READY;
  logic        BufSel;
  logic        SwapPending;
  logic        Busy;

  int tests_run;
  int tests_failed;

  fb_write_arbiter #(.N_REQ(4), .ADDR_W(19), .DATA_W(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .VGA_VS(VGA_VS), .FrameDone(FrameDone),
    .Req(Req), .Addr(Addr), .Data(Data), .Last(Last),
    .Grant(Grant), .Ack(Ack), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_READY(MEM_READY), .BufSel(BufSel),
    .SwapPending(SwapPending), .Busy(Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic set_pix(input int i, input logic [18:0] a, input logic [7:0] d);
    Addr[i*19 +: 19] = a;
    Data[i*8 +: 8]   = d;
  endtask

  task automatic apply_reset();
    RESET_N   = 1'b0;
    Req       = '0;
    Last      = '0;
    FrameDone = 1'b0;
    VGA_VS    = 1'b1;
    MEM_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; VGA_VS = 1'b1; FrameDone = 1'b0; Req = '0;
    Addr = '0; Data = '0; Last = '0; MEM_READY = 1'b1;
    smp();
    tests_run++;
    if ({Grant, Ack, MEM_WE, BufSel, SwapPending, Busy} !== 12'h000) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl got=%h exp=000", {Grant, Ack, MEM_WE, BufSel, SwapPending, Busy});
    end
    tests_run++;
    if ({MEM_ADDR, MEM_WDATA} !== 28'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mem got=%h exp=0", {MEM_ADDR, MEM_WDATA});
    end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
  endtask

  task automatic test_burst();
    apply_reset();
    Req = 4'b0010; set_pix(1, 19'h10, 8'h11);
    smp();
    tests_run++;
    if (Grant !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL burst_c0_grant got=%b exp=0000", Grant);
    end
    tick(); smp();
    tests_run++;
    if ({Grant, Ack, MEM_WE} !== {4'b0010, 4'b0010, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL burst_c1 got=%h exp=%h", {Grant, Ack, MEM_WE}, {4'b0010, 4'b0010, 1'b0});
    end
    tick(); set_pix(1, 19'h11, 8'h12); smp();
    tests_run++;
    if ({Ack, MEM_WE, MEM_ADDR, MEM_WDATA} !== {4'b0010, 1'b1, 20'h00010, 8'h11}) begin
      tests_failed++; $display("[TB] FAIL burst_c2 got=%h exp=%h", {Ack, MEM_WE, MEM_ADDR, MEM_WDATA}, {4'b0010, 1'b1, 20'h00010, 8'h11});
    end
    tick(); set_pix(1, 19'h12, 8'h13); Last = 4'b0010; smp();
    tests_run++;
    if ({Grant, Ack, MEM_WE, MEM_ADDR, MEM_WDATA} !== {4'b0010, 4'b0010, 1'b1, 20'h00011, 8'h12}) begin
      tests_failed++; $display("[TB] FAIL burst_c3 got=%h exp=%h", {Grant, Ack, MEM_WE, MEM_ADDR, MEM_WDATA}, {4'b0010, 4'b0010, 1'b1, 20'h00011, 8'h12});
    end
    tick(); Req = '0; Last = '0; smp();
    tests_run++;
    if ({Grant, Ack, MEM_WE, MEM_ADDR, MEM_WDATA, Busy} !== {4'b0000, 4'b0000, 1'b1, 20'h00012, 8'h13, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL burst_c4 got=%h exp=%h", {Grant, Ack, MEM_WE, MEM_ADDR, MEM_WDATA, Busy}, {4'b0000, 4'b0000, 1'b1, 20'h00012, 8'h13, 1'b1});
    end
    tick(); smp();
    tests_run++;
    if ({MEM_WE, Busy} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL burst_idle got=%b exp=00", {MEM_WE, Busy});
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_grant [6];
    logic [20:0] exp_mem   [6];
    exp_grant = '{4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
    exp_mem   = '{21'h000000, 21'h000000, {1'b1, 20'h00100}, {1'b0, 20'h00100},
                  {1'b1, 20'h00200}, {1'b0, 20'h00200}};
    apply_reset();
    Req = 4'b0101; Last = 4'b0101;
    set_pix(0, 19'h100, 8'hA0); set_pix(2, 19'h200, 8'hC0);
    for (int c = 0; c < 6; c++) begin
      if (c != 0) tick();
      smp();
      tests_run++;
      if ({Grant, Ack, MEM_WE, MEM_ADDR} !== {exp_grant[c], exp_grant[c], exp_mem[c]}) begin
        tests_failed++;
        $display("[TB] FAIL rr_c%0d got=%h exp=%h", c, {Grant, Ack, MEM_WE, MEM_ADDR}, {exp_grant[c], exp_grant[c], exp_mem[c]});
      end
    end
    tick(); Req = '0; Last = '0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    Req = 4'b0100; set_pix(2, 19'h30, 8'hB0);
    smp();
    tick(); smp();
    tests_run++;
    if ({Ack, MEM_WE} !== {4'b0100, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL bp_first_ack got=%h exp=%h", {Ack, MEM_WE}, {4'b0100, 1'b0});
    end
    tick(); set_pix(2, 19'h31, 8'hB1); MEM_READY = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick();
      smp();
      tests_run++;
      if ({Grant, Ack, MEM_WE, MEM_ADDR, MEM_WDATA} !== {4'b0100, 4'b0000, 1'b1, 20'h00030, 8'hB0}) begin
        tests_failed++;
        $display("[TB] FAIL bp_stall%0d got=%h exp=%h", k, {Grant, Ack, MEM_WE, MEM_ADDR, MEM_WDATA}, {4'b0100, 4'b0000, 1'b1, 20'h00030, 8'hB0});
      end
    end
    tick(); MEM_READY = 1'b1; smp();
    tests_run++;
    if ({Ack, MEM_WE, MEM_ADDR} !== {4'b0100, 1'b1, 20'h00030}) begin
      tests_failed++; $display("[TB] FAIL bp_resume got=%h exp=%h", {Ack, MEM_WE, MEM_ADDR}, {4'b0100, 1'b1, 20'h00030});
    end
    tick(); set_pix(2, 19'h32, 8'hB2); Last = 4'b0100; smp();
    tests_run++;
    if ({Ack, MEM_ADDR, MEM_WDATA} !== {4'b0100, 20'h00031, 8'hB1}) begin
      tests_failed++; $display("[TB] FAIL bp_second got=%h exp=%h", {Ack, MEM_ADDR, MEM_WDATA}, {4'b0100, 20'h00031, 8'hB1});
    end
    tick(); Req = '0; Last = '0; smp();
    tests_run++;
    if ({Grant, MEM_WE, MEM_ADDR, MEM_WDATA} !== {4'b0000, 1'b1, 20'h00032, 8'hB2}) begin
      tests_failed++; $display("[TB] FAIL bp_last got=%h exp=%h", {Grant, MEM_WE, MEM_ADDR, MEM_WDATA}, {4'b0000, 1'b1, 20'h00032, 8'hB2});
    end
  endtask

  task automatic test_frame_done();
    apply_reset();
    Req = 4'b1000; set_pix(3, 19'h40, 8'hD0);
    smp();
    tick(); smp();
    tests_run++;
    if ({Grant, Ack} !== 8'b1000_1000) begin
      tests_failed++; $display("[TB] FAIL fd_grant got=%b exp=10001000", {Grant, Ack});
    end
    tick(); set_pix(3, 19'h41, 8'hD1); FrameDone = 1'b1; smp();
    tick(); FrameDone = 1'b0; set_pix(3, 19'h42, 8'hD2); Last = 4'b1001;
    Req = 4'b1001; set_pix(0, 19'h50, 8'hE0); smp();
    tests_run++;
    if ({Grant, Ack, SwapPending, BufSel} !== {4'b1000, 4'b1000, 1'b1, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL fd_burst_cont got=%b exp=%b", {Grant, Ack, SwapPending, BufSel}, {4'b1000, 4'b1000, 1'b1, 1'b0});
    end
    tick(); Req = 4'b0001; Last = 4'b0001; smp();
    tests_run++;
    if ({Grant, MEM_WE, MEM_ADDR} !== {4'b0000, 1'b1, 20'h00042}) begin
      tests_failed++; $display("[TB] FAIL fd_burst_done got=%h exp=%h", {Grant, MEM_WE, MEM_ADDR}, {4'b0000, 1'b1, 20'h00042});
    end
    for (int k = 0; k < 4; k++) begin
      tick(); smp();
      tests_run++;
      if ({Grant, Ack, BufSel, SwapPending} !== {4'b0000, 4'b0000, 1'b0, 1'b1}) begin
        tests_failed++;
        $display("[TB] FAIL fd_wait%0d got=%b exp=%b", k, {Grant, Ack, BufSel, SwapPending}, {4'b0000, 4'b0000, 1'b0, 1'b1});
      end
    end
    tick(); VGA_VS = 1'b0; smp();
    tick(); VGA_VS = 1'b1; smp();
    tests_run++;
    if ({BufSel, SwapPending, Grant} !== {1'b1, 1'b0, 4'b0000}) begin
      tests_failed++; $display("[TB] FAIL fd_swap got=%b exp=%b", {BufSel, SwapPending, Grant}, {1'b1, 1'b0, 4'b0000});
    end
    tick(); smp();
    tests_run++;
    if ({Grant, Ack} !== 8'b0001_0001) begin
      tests_failed++; $display("[TB] FAIL fd_post_grant got=%b exp=00010001", {Grant, Ack});
    end
    tick(); Req = '0; Last = '0; smp();
    tests_run++;
    if ({MEM_WE, MEM_ADDR, MEM_WDATA} !== {1'b1, 20'h80050, 8'hE0}) begin
      tests_failed++; $display("[TB] FAIL fd_new_buf got=%h exp=%h", {MEM_WE, MEM_ADDR, MEM_WDATA}, {1'b1, 20'h80050, 8'hE0});
    end
  endtask

  task automatic test_double_frame_done();
    apply_reset();
    FrameDone = 1'b1; Req = 4'b0001; Last = 4'b0001; set_pix(0, 19'h07, 8'h77);
    smp();
    tests_run++;
    if ({Grant, Ack} !== 8'h00) begin
      tests_failed++; $display("[TB] FAIL dfd_c0 got=%b exp=00000000", {Grant, Ack});
    end
    tick(); smp();
    tests_run++;
    if ({Grant, Ack, SwapPending} !== {8'h00, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL dfd_swap_wins got=%b exp=%b", {Grant, Ack, SwapPending}, {8'h00, 1'b1});
    end
    tick(); FrameDone = 1'b0; VGA_VS = 1'b0; smp();
    tests_run++;
    if ({BufSel, Grant} !== 5'b0_0000) begin
      tests_failed++; $display("[TB] FAIL dfd_pre_swap got=%b exp=00000", {BufSel, Grant});
    end
    tick(); smp();
    tests_run++;
    if ({BufSel, SwapPending, Grant} !== 6'b10_0000) begin
      tests_failed++; $display("[TB] FAIL dfd_swap got=%b exp=100000", {BufSel, SwapPending, Grant});
    end
    tick(); smp();
    tests_run++;
    if ({Grant, Ack, BufSel} !== 9'b0001_0001_1) begin
      tests_failed++; $display("[TB] FAIL dfd_grant got=%b exp=000100011", {Grant, Ack, BufSel});
    end
    tick(); Req = '0; Last = '0; smp();
    tests_run++;
    if ({MEM_WE, MEM_ADDR} !== {1'b1, 20'h80007}) begin
      tests_failed++; $display("[TB] FAIL dfd_addr got=%h exp=%h", {MEM_WE, MEM_ADDR}, {1'b1, 20'h80007});
    end
    tick(); tick(); smp();
    tests_run++;
    if ({BufSel, SwapPending} !== 2'b10) begin
      tests_failed++; $display("[TB] FAIL dfd_single_toggle got=%b exp=10", {BufSel, SwapPending});
    end
    VGA_VS = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    // Continues from the previous state: BufSel=1 and the pointer sits at 1.
    tick();
    Req = 4'b0100; Last = '0; set_pix(2, 19'h60, 8'h66);
    smp();
    tick(); smp();
    tick(); set_pix(2, 19'h61, 8'h67); smp();
    tests_run++;
    if ({Grant, MEM_WE, BufSel} !== {4'b0100, 1'b1, 1'b1}) begin
      tests_failed++; $display("[TB] FAIL rst_pre got=%b exp=%b", {Grant, MEM_WE, BufSel}, {4'b0100, 1'b1, 1'b1});
    end
    #1 RESET_N = 1'b0;
    #1;
    tests_run++;
    if ({Grant, Ack, MEM_WE, BufSel, SwapPending, Busy} !== 12'h000) begin
      tests_failed++; $display("[TB] FAIL rst_async got=%h exp=000", {Grant, Ack, MEM_WE, BufSel, SwapPending, Busy});
    end
    Req = '0;
    @(posedge CLK); #1;
    RESET_N = 1'b1; Req = 4'b0101; Last = 4'b0101;
    set_pix(0, 19'h01, 8'h01); set_pix(2, 19'h02, 8'h02);
    smp();
    tick(); smp();
    tests_run++;
    if ({Grant, Ack} !== 8'b0001_0001) begin
      tests_failed++; $display("[TB] FAIL rst_ptr got=%b exp=00010001", {Grant, Ack});
    end
    tick(); Req = '0; Last = '0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_burst();
    test_round_robin();
    test_backpressure();
    test_frame_done();
    test_double_frame_done();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
